// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for an N-digit common-anode
//            seven-segment display. One nibble per slot is presented to a
//            shared external decoder while one active-low anode is driven.
//            Displayed data is double-buffered (shadow/pending) and swaps only
//            at frame boundaries. Each slot starts with DEAD_CYCLES of
//            all-anodes-off to suppress ghosting.
// Ports    : clk          - system clock
//            reset_n      - asynchronous active-low reset
//            value_in     - 4*N_DIGITS nibbles, digit 0 least significant
//            digit_en     - per-digit anode enable
//            load         - single-cycle capture strobe for value_in
//            load_ack     - one-cycle pulse after the shadow register updates
//            digit_bcd    - nibble for the shared decoder
//            anodes       - active-low digit selects
//            frame_start  - one-cycle pulse at the start of each frame
// Options  : `define LEADING_ZERO_BLANK_EN to blank leading zero digits
//            (digit 0 is never blanked).
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    load,
  output logic                    load_ack,
  output logic [3:0]              digit_bcd,
  output logic [N_DIGITS-1:0]     anodes,
  output logic                    frame_start
);

  localparam int c_cnt_w = $clog2(REFRESH_DIV);
  localparam int c_idx_w = $clog2(N_DIGITS);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_dead_last = c_cnt_w'(DEAD_CYCLES - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_cnt_w-1:0]      r_cnt;
  logic [c_idx_w-1:0]      r_idx;
  logic [4*N_DIGITS-1:0]   r_shadow;
  logic [4*N_DIGITS-1:0]   r_pend_buf;
  logic                    r_pend;
  logic [N_DIGITS-1:0]     r_en_q;
  logic                    r_load_ack;
  logic                    r_frame_start;
  logic                    w_slot_end;
  logic                    w_boundary;
  logic [N_DIGITS-1:0]     w_blank;

  assign w_slot_end = (r_cnt == c_cnt_last);
  assign w_boundary = w_slot_end && (r_idx == c_idx_last);

  // Leading-zero blanking: digit i is blank when every nibble from i upward
  // is zero; digit 0 always shows so a zero value displays a single "0".
`ifdef LEADING_ZERO_BLANK_EN
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_digit0
        assign w_blank[gi] = 1'b0;
      end else begin : g_digitn
        assign w_blank[gi] = ~(|r_shadow[4*N_DIGITS-1:4*gi]);
      end
    end
  endgenerate
`else
  assign w_blank = '0;
`endif

  // Slot counter and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_DEAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and anode decode
  always_comb begin
    w_state_nxt = r_state;
    anodes      = '1;
    case (r_state)
      ST_DEAD: begin
        if (r_cnt == c_dead_last) begin
          w_state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        anodes[r_idx] = ~(r_en_q[r_idx] & ~w_blank[r_idx]);
        if (w_slot_end) begin
          w_state_nxt = ST_DEAD;
        end
      end
      default: w_state_nxt = ST_DEAD;
    endcase
  end

  // Double buffer: loads collect in pend_buf (latest wins) and move to the
  // shadow only at the frame boundary. A load arriving in the boundary cycle
  // itself bypasses pend_buf and supersedes any pending value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow      <= '0;
      r_pend_buf    <= '0;
      r_pend        <= 1'b0;
      r_load_ack    <= 1'b0;
      r_en_q        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_load_ack <= 1'b0;
      if (w_boundary) begin
        if (load) begin
          r_shadow   <= value_in;
          r_pend     <= 1'b0;
          r_load_ack <= 1'b1;
        end else if (r_pend) begin
          r_shadow   <= r_pend_buf;
          r_pend     <= 1'b0;
          r_load_ack <= 1'b1;
        end
      end else if (load) begin
        r_pend_buf <= value_in;
        r_pend     <= 1'b1;
      end
      r_en_q        <= digit_en;
      r_frame_start <= (r_cnt == '0) && (r_idx == '0);
    end
  end

  assign digit_bcd   = r_shadow[{r_idx, 2'b00} +: 4];
  assign load_ack    = r_load_ack;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_ctrl
// Purpose  : Directed self-checking bench for seven_seg_scan_ctrl with
//            N_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2 (32-cycle frame).
//            fc is the frame-relative cycle count since reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int DC    = 2;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        load = 1'b0;
  logic        load_ack;
  logic [3:0]  digit_bcd;
  logic [3:0]  anodes;
  logic        frame_start;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          fc = 0;
  logic [15:0] exp_shadow = '0;
  logic [15:0] nxt_shadow = '0;
  int          swap_fc = -1;
  logic [3:0]  exp_en = '0;
  logic [3:0]  en_nxt = '0;
  int          en_fc = -1;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .value_in    (value_in),
    .digit_en    (digit_en),
    .load        (load),
    .load_ack    (load_ack),
    .digit_bcd   (digit_bcd),
    .anodes      (anodes),
    .frame_start (frame_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s fc=%0d: got %0h expected %0h", tag, fc, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_anodes(int f, logic [3:0] en, logic [15:0] sh);
    int         c = f % RD;
    int         i = (f / RD) % N;
    logic [3:0] a = 4'hF;
    logic       blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0) begin
      blank = 1'b1;
      for (int k = i; k < N; k++) begin
        if (sh[4*k +: 4] != 4'h0) blank = 1'b0;
      end
    end
`endif
    if (c >= DC && en[i] && !blank) a[i] = 1'b0;
    return a;
  endfunction

  task automatic check_cycle();
    check_eq("anodes", anodes, exp_anodes(fc, exp_en, exp_shadow));
    check_eq("digit_bcd", digit_bcd, exp_shadow[4*((fc / RD) % N) +: 4]);
    check_eq("frame_start", frame_start, (fc % FRAME) == 1);
    check_eq("load_ack", load_ack, fc == swap_fc);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    fc++;
    if (fc == en_fc) exp_en = en_nxt;
    if (fc == swap_fc) exp_shadow = nxt_shadow;
    check_cycle();
  endtask

  task automatic run_to(input int t);
    while (fc < t) tick();
  endtask

  // One-cycle load in the current cycle; swap is the fc where it shows.
  task automatic do_load(input logic [15:0] v, input int swap);
    load       = 1'b1;
    value_in   = v;
    nxt_shadow = v;
    swap_fc    = swap;
    tick();
    load     = 1'b0;
    value_in = 16'hBEEF;
  endtask

  task automatic set_en(input logic [3:0] v);
    digit_en = v;
    en_nxt   = v;
    en_fc    = fc + 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_anodes"}, anodes, 4'hF);
    check_eq({tag, "_bcd"}, digit_bcd, 4'h0);
    check_eq({tag, "_fstart"}, frame_start, 1'b0);
    check_eq({tag, "_ack"}, load_ack, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");

    // Release with all digits enabled; en_q is 0 in cycle 0
    reset_n = 1'b1;
    fc = 0; exp_en = '0; set_en(4'hF);
    check_cycle();
    run_to(64);

    // Frame-synchronised load in frame cycle 5
    run_to(69);
    do_load(16'h12AF, 96);
    run_to(96);
    check_eq("sync_slot0", digit_bcd, 4'hF);
    run_to(106);
    check_eq("sync_slot1", digit_bcd, 4'hA);
    check_eq("sync_an1", anodes, 4'b1101);
    run_to(128);

    // Latest wins
    run_to(131);
    do_load(16'h1111, 160);
    run_to(148);
    do_load(16'h2222, 160);
    run_to(185);
    check_eq("latest_slot3", digit_bcd, 4'h2);
    run_to(192);

    // Boundary collision: pending 3333, bypass 4444 in the boundary cycle
    run_to(200);
    do_load(16'h3333, 224);
    run_to(223);
    do_load(16'h4444, 224);
    run_to(290);   // no ack and no 3333 at 256/288: pend was cleared
    check_eq("coll_hold", digit_bcd, 4'h4);

    // Enable mask 0101, then reset at frame cycle 13 with a pending load
    set_en(4'b0101);
    run_to(325);
    do_load(16'h5555, 352);
    run_to(333);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("hold_rst");
    reset_n = 1'b1;
    fc = 0; exp_shadow = '0; swap_fc = -1; exp_en = '0; en_fc = -1;
    set_en(4'b0101);
    check_cycle();
    run_to(40);    // pending 5555 must not appear at 32

    // Blanking patterns (blank only when the macro is defined)
    set_en(4'hF);
    run_to(45);
    do_load(16'h0070, 64);
    run_to(100);
    do_load(16'h0000, 128);
    run_to(160);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
